// File: rtl/dyn_pkg.sv
// Shared constants and FSM state type for the dynamic range compressor.
package dyn_pkg;
   localparam int SAMPLE_W       = 16;
   localparam int GAIN_FRAC_BITS = 14;
   localparam logic [15:0] UNITY_GAIN = 16'd16384;
   localparam logic [15:0] MIN_GAIN   = 16'd1;

   typedef enum logic [1:0] {IDLE, ATTACK, HOLD, RELEASE} comp_state_e;
endpackage

// File: rtl/dyn_compressor_abs_sat.sv
// Saturating magnitude of a signed sample: the most negative code maps to the largest positive one.
module abs_sat
   import dyn_pkg::*;
(
   input  logic signed [SAMPLE_W-1:0] sample,
   output logic        [SAMPLE_W-1:0] mag
);
   localparam logic signed [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic        [SAMPLE_W-1:0] MAX_POS  = {1'b0, {(SAMPLE_W-1){1'b1}}};

   always_comb begin
      mag = sample;
      if (sample == MOST_NEG) begin
         mag = MAX_POS;
      end else if (sample[SAMPLE_W-1]) begin
         mag = -sample;
      end
   end
endmodule

// File: rtl/dyn_compressor.sv
// Dynamic range compressor: two-stage pipeline with attack/hold/release gain control.
// Define COMP_HARD_LIMIT_EN to add a hard output limiter at +/-LIMIT_LEVEL driving clip_flag.
module dyn_compressor
   import dyn_pkg::*;
#(
   parameter int THRESHOLD    = 8000,
   parameter int RATIO_SHIFT  = 2,
   parameter int ATTACK_SHIFT = 3,
   parameter int RELEASE_STEP = 4,
   parameter int HOLD_TIME    = 2400,
   parameter int LIMIT_LEVEL  = 30000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       in_valid,
   input  logic signed [SAMPLE_W-1:0] in_sample,
   output logic                       out_valid,
   output logic signed [SAMPLE_W-1:0] out_sample,
   output logic        [SAMPLE_W-1:0] gain,
   output logic                       comp_active,
   output logic                       clip_flag
);
   localparam int HOLD_W = $clog2(HOLD_TIME + 1);
   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_TIME);
   localparam logic [31:0]          THRESH_U  = 32'(THRESHOLD);
   localparam logic signed [32:0]   SAT_MAX   = 33'sd32767;
   localparam logic signed [32:0]   SAT_MIN   = -33'sd32768;

   comp_state_e state, state_next;
   logic [HOLD_W-1:0]          hold_cnt, hold_next;
   logic [SAMPLE_W-1:0]        gain_next, attack_dec;
   logic [SAMPLE_W:0]          gain_rel;
   logic                       s1_valid;
   logic signed [SAMPLE_W-1:0] s1_sample, sat_out, limited, out_next;
   logic [SAMPLE_W-1:0]        mag, s1_mag;
   logic signed [32:0]         prod, scaled;
   logic [31:0]                mag_ext, level, ceil_lvl;
   logic                       overshoot;

   abs_sat u_abs_sat (
      .sample (in_sample),
      .mag    (mag)
   );

   // Stage 2 datapath: gain applied to the sample and the knee test use the same pre-update gain.
   always_comb begin
      prod     = 33'(s1_sample) * $signed({17'b0, gain});
      scaled   = prod >>> GAIN_FRAC_BITS;
      sat_out  = scaled[SAMPLE_W-1:0];
      if (scaled > SAT_MAX) begin
         sat_out = 16'sh7FFF;
      end else if (scaled < SAT_MIN) begin
         sat_out = 16'sh8000;
      end
      mag_ext   = {16'b0, s1_mag};
      level     = (mag_ext * {16'b0, gain}) >> GAIN_FRAC_BITS;
      ceil_lvl  = THRESH_U + ((mag_ext - THRESH_U) >> RATIO_SHIFT);
      overshoot = (mag_ext > THRESH_U) && (level > ceil_lvl);
   end

`ifdef COMP_HARD_LIMIT_EN
   localparam logic signed [32:0] LIM_HI = 33'(LIMIT_LEVEL);
   localparam logic signed [32:0] LIM_LO = -33'(LIMIT_LEVEL);
   logic clip_next;

   always_comb begin
      limited   = sat_out;
      clip_next = 1'b0;
      if (scaled > LIM_HI) begin
         limited   = LIM_HI[SAMPLE_W-1:0];
         clip_next = 1'b1;
      end else if (scaled < LIM_LO) begin
         limited   = LIM_LO[SAMPLE_W-1:0];
         clip_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_flag <= 1'b0;
      end else begin
         clip_flag <= s1_valid && enable && clip_next;
      end
   end
`else
   logic unused_limit;
   assign unused_limit = |LIMIT_LEVEL;
   assign limited      = sat_out;
   assign clip_flag    = 1'b0;
`endif

   assign out_next    = enable ? limited : s1_sample;
   assign comp_active = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_sample  <= '0;
         s1_mag     <= '0;
         out_valid  <= 1'b0;
         out_sample <= '0;
      end else begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (in_valid) begin
            s1_sample <= in_sample;
            s1_mag    <= mag;
         end
         if (s1_valid) begin
            out_sample <= out_next;
         end
      end
   end

   // Gain envelope: only advances when a sample leaves stage 2.
   always_comb begin
      state_next = state;
      gain_next  = gain;
      hold_next  = hold_cnt;
      attack_dec = gain >> ATTACK_SHIFT;
      if (attack_dec == '0) begin
         attack_dec = MIN_GAIN;
      end
      gain_rel = {1'b0, gain} + 17'(RELEASE_STEP);
      if (s1_valid) begin
         if (!enable) begin
            state_next = IDLE;
            gain_next  = UNITY_GAIN;
            hold_next  = '0;
         end else if (overshoot) begin
            state_next = ATTACK;
            gain_next  = (gain > attack_dec) ? (gain - attack_dec) : MIN_GAIN;
            hold_next  = '0;
         end else begin
            case (state)
               ATTACK, HOLD: begin
                  hold_next  = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HOLD_W'(1);
                  state_next = (hold_next == HOLD_LAST) ? RELEASE : HOLD;
               end
               RELEASE: begin
                  if (gain_rel >= {1'b0, UNITY_GAIN}) begin
                     gain_next  = UNITY_GAIN;
                     state_next = IDLE;
                     hold_next  = '0;
                  end else begin
                     gain_next = gain_rel[SAMPLE_W-1:0];
                  end
               end
               default: begin
                  gain_next = UNITY_GAIN;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gain     <= UNITY_GAIN;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         gain     <= gain_next;
         hold_cnt <= hold_next;
      end
   end
endmodule

// File: tb/tb_dyn_compressor.sv
// Self-checking bench for dyn_compressor: directed scenarios plus random samples against a behavioural model.
module tb_dyn_compressor;
   localparam int TH = 8000, RSH = 2, ASH = 3, RSTEP = 4, HT = 2400, LIM = 30000;
   localparam int UNITY = 16384;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic in_valid = 1'b0;
   logic signed [15:0] in_sample = '0;
   logic out_valid;
   logic signed [15:0] out_sample;
   logic [15:0] gain;
   logic comp_active;
   logic clip_flag;

   int checks = 0;
   int errors = 0;

   // Model state: phase 0 idle, 1 attack, 2 hold, 3 release.
   int m_gain = UNITY, m_phase = 0, m_hold = 0;
   int prev_v = 0, prev_s = 0;
   int g_prev = UNITY, run_len = 0, last_run = 0;

   dyn_compressor #(
      .THRESHOLD(TH), .RATIO_SHIFT(RSH), .ATTACK_SHIFT(ASH),
      .RELEASE_STEP(RSTEP), .HOLD_TIME(HT), .LIMIT_LEVEL(LIM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
      .in_sample(in_sample), .out_valid(out_valid), .out_sample(out_sample),
      .gain(gain), .comp_active(comp_active), .clip_flag(clip_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog expired observed timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Sample-level reference: applies the gain law directly with integer arithmetic.
   task automatic model_step(input int s, input bit en, output int o, output int clip);
      int mag, level, ceil_l, dec;
      bit over;
      clip = 0;
      mag = (s < 0) ? -s : s;
      if (mag > 32767) mag = 32767;
      if (!en) begin
         o = s;
         m_gain = UNITY; m_phase = 0; m_hold = 0;
         return;
      end
      o = (s * m_gain) >>> 14;
      if (o > 32767) o = 32767;
      if (o < -32768) o = -32768;
`ifdef COMP_HARD_LIMIT_EN
      if (o > LIM) begin o = LIM; clip = 1; end
      else if (o < -LIM) begin o = -LIM; clip = 1; end
`endif
      level  = (mag * m_gain) >>> 14;
      ceil_l = TH + ((mag - TH) >>> RSH);
      over   = (mag > TH) && (level > ceil_l);
      if (over) begin
         dec = m_gain >>> ASH;
         if (dec < 1) dec = 1;
         m_gain = m_gain - dec;
         if (m_gain < 1) m_gain = 1;
         m_phase = 1; m_hold = 0;
      end else if (m_phase == 1 || m_phase == 2) begin
         m_hold++;
         m_phase = (m_hold >= HT) ? 3 : 2;
      end else if (m_phase == 3) begin
         m_gain += RSTEP;
         if (m_gain >= UNITY) begin m_gain = UNITY; m_phase = 0; m_hold = 0; end
      end else begin
         m_gain = UNITY;
      end
   endtask

   // One clock: drive inputs on the falling edge, check the sample leaving stage 2 just after the rising edge.
   task automatic apply_stimulus(input bit v, input int s, input bit en);
      int o, c;
      @(negedge clk);
      in_valid  = v;
      in_sample = 16'(s);
      enable    = en;
      @(posedge clk);
      #1;
      check_output("out_valid", out_valid, prev_v);
      if (prev_v != 0) begin
         model_step(prev_s, en, o, c);
         check_output("out_sample", out_sample, o);
         check_output("gain", gain, m_gain);
         check_output("comp_active", comp_active, (m_phase != 0) ? 1 : 0);
         check_output("clip_flag", clip_flag, c);
         if (int'(gain) == g_prev) run_len++;
         else begin last_run = run_len; run_len = 0; end
         g_prev = gain;
      end
      prev_v = v;
      prev_s = s;
   endtask

   initial begin
      int old_g;
      bit cap;
      logic signed [15:0] r;
      int s;
      bit en;

      repeat (2) @(negedge clk);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_out_sample", out_sample, 0);
      check_output("rst_gain", gain, UNITY);
      check_output("rst_comp_active", comp_active, 0);
      check_output("rst_clip_flag", clip_flag, 0);
      rst_n = 1'b1;

      // Below the knee: unity gain, straight through.
      for (int i = 0; i < 10; i++) apply_stimulus(1, 4000, 1);
      check_output("below_knee_out", out_sample, 4000);
      check_output("below_knee_gain", gain, UNITY);
      check_output("below_knee_active", comp_active, 0);

      // Step to 24000 and let the attack settle.
      for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 1);
      for (int i = 0; i < 20; i++) begin
         old_g = gain;
         apply_stimulus(1, 24000, 1);
         check_output("attack_monotonic", (int'(gain) <= old_g) ? 1 : 0, 1);
      end
      check_output("settle_gain_range", (gain >= 16'd7168 && gain <= 16'd8192) ? 1 : 0, 1);
      check_output("settle_out_range", (out_sample >= 10500 && out_sample <= 12000) ? 1 : 0, 1);
      check_output("settle_active", comp_active, 1);

      // Silence: hold for HT samples, then release in RSTEP increments back to unity.
      cap = 0;
      for (int i = 0; i < 6000 && comp_active; i++) begin
         old_g = gain;
         apply_stimulus(1, 0, 1);
         if (int'(gain) != old_g) begin
            if (!cap) begin
               cap = 1;
               check_output("hold_len", last_run, HT);
            end
            check_output("release_step", gain, (old_g + RSTEP > UNITY) ? UNITY : old_g + RSTEP);
         end
      end
      check_output("release_seen", cap, 1);
      check_output("release_idle", comp_active, 0);
      check_output("release_gain", gain, UNITY);

      // Most negative sample at unity gain.
      apply_stimulus(1, -32768, 1);
      apply_stimulus(0, 0, 1);
      check_output("neg_full_scale", out_sample, -32768);

      // Full-scale positive sample from unity, compressing then bypassed.
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 0, 0);
      apply_stimulus(1, 32000, 1);
      apply_stimulus(0, 0, 1);
`ifdef COMP_HARD_LIMIT_EN
      check_output("limit_out", out_sample, LIM);
      check_output("limit_clip", clip_flag, 1);
`else
      check_output("limit_out", out_sample, 32000);
      check_output("limit_clip", clip_flag, 0);
`endif
      apply_stimulus(1, 32000, 0);
      apply_stimulus(0, 0, 0);
      check_output("bypass_out", out_sample, 32000);
      check_output("bypass_clip", clip_flag, 0);

      // Random traffic with gaps, varied amplitude and occasional enable toggles.
      en = 1;
      for (int i = 0; i < 600; i++) begin
         r = 16'($urandom);
         s = int'(r) >>> $urandom_range(0, 3);
         if ($urandom_range(0, 31) == 0) en = ~en;
         apply_stimulus(($urandom_range(0, 3) != 0), s, en);
      end

      // Asynchronous reset in the middle of an attack.
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 0, 0);
      for (int i = 0; i < 4; i++) apply_stimulus(1, 24000, 1);
      check_output("pre_reset_attack", (gain < 16'd16384) ? 1 : 0, 1);
      #3;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_output("async_rst_gain", gain, UNITY);
      check_output("async_rst_out_valid", out_valid, 0);
      check_output("async_rst_out_sample", out_sample, 0);
      check_output("async_rst_active", comp_active, 0);
      m_gain = UNITY; m_phase = 0; m_hold = 0; prev_v = 0;
      g_prev = UNITY; run_len = 0;
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(0, 0, 1);
      apply_stimulus(0, 0, 1);
      apply_stimulus(1, 1000, 1);
      apply_stimulus(0, 0, 1);
      check_output("post_rst_first_out", out_sample, 1000);
      apply_stimulus(0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
